// File: rtl/sobel_window_generator.sv
// rtl/sobel_window_generator.sv - raster pixel stream to 3x3 Sobel neighbourhood windows
module sobel_window_generator #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic [71:0] window_data_out,
    output logic        window_data_out_valid,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [7:0]    r_lb0 [IMG_WIDTH];
    logic [7:0]    r_lb1 [IMG_WIDTH];
    logic [7:0]    w_lb0_rd;
    logic [7:0]    w_lb1_rd;

    // Window columns c-2 (suffix 1) and c-1 (suffix 2); column c is the
    // incoming {lb1, lb0, pixel} triple, completing the 3x3 array.
    logic [7:0]    r_top1, r_top2, r_mid1, r_mid2, r_bot1, r_bot2;

    logic          w_col_last;
    logic          w_row_last;
    logic          w_run;
    logic          w_windowed;
    logic          w_frame_end;
    logic [71:0]   w_window;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_lb0_rd   = r_lb0[r_col];
    assign w_lb1_rd   = r_lb1[r_col];
    assign w_window   = {pixel_in, r_bot2, r_bot1,
                         w_lb0_rd, r_mid2, r_mid1,
                         w_lb1_rd, r_top2, r_top1};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: FILL until row 1 completes, RUN until the frame's last pixel
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: if (pixel_in_valid && w_col_last && r_row == ROW_ONE)    w_state_next = S_RUN;
            S_RUN:  if (pixel_in_valid && w_col_last && w_row_last)          w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    // FSM outputs: a window exists only for interior columns while in RUN
    always_comb begin
        w_run       = (r_state == S_RUN);
        w_windowed  = pixel_in_valid && w_run && (r_col >= COL_TWO);
        w_frame_end = pixel_in_valid && w_run && w_col_last && w_row_last;
    end

    // Raster position counters, wrapping at line and frame ends
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pixel_in_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffer update; reads above see the pre-write contents
    always_ff @(posedge clk) begin
        if (pixel_in_valid) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= pixel_in;
        end
    end

    // Window columns shift left on every accepted pixel and hold otherwise
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_top1 <= '0; r_top2 <= '0;
            r_mid1 <= '0; r_mid2 <= '0;
            r_bot1 <= '0; r_bot2 <= '0;
        end else if (pixel_in_valid) begin
            r_top1 <= r_top2; r_top2 <= w_lb1_rd;
            r_mid1 <= r_mid2; r_mid2 <= w_lb0_rd;
            r_bot1 <= r_bot2; r_bot2 <= pixel_in;
        end
    end

    // Output register: loads only on windowed pixels, valid/done are one-cycle pulses
    always_ff @(posedge clk) begin
        if (!rstN) begin
            window_data_out       <= '0;
            window_data_out_valid <= 1'b0;
            frame_done            <= 1'b0;
        end else begin
            window_data_out_valid <= w_windowed;
            frame_done            <= w_frame_end;
            if (w_windowed) begin
                window_data_out <= w_window;
            end
        end
    end

endmodule

// File: doc/sobel_window_generator.md
Name: sobel_window_generator

Overview:
- Streaming producer for the 3x3 Sobel stage: takes a raster-order 8-bit grayscale pixel stream and emits one 72-bit 3x3 neighbourhood window per interior pixel.
- Sits between the pixel source (smoothing or input stage) and the gradient stage.
- Drives that stage's window data/valid pair directly; no backpressure.
- Uses two internal line buffers plus a 3x3 register array; frame boundaries are tracked with internal row/column counters.

Parameters:
- IMG_WIDTH, 512, pixels per line (minimum 3)
- IMG_HEIGHT, 512, lines per frame (minimum 3)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstN  input  1  synchronous active-low reset, sampled on rising edge of clk
- pixel_in  input  8  unsigned pixel, raster order (row-major, left to right, top to bottom)
- pixel_in_valid  input  1  pixel_in accepted on every clk edge where high; gaps allowed anywhere
- window_data_out  output  72  3x3 window, byte i = bits [i*8+:8], row-major, byte 0 top-left, byte 8 bottom-right
- window_data_out_valid  output  1  one-cycle qualifier per window
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (rstN low at clk edge): window_data_out=0, window_data_out_valid=0, frame_done=0, row/col counters=0, FSM=FILL.
  - Line-buffer contents need not be cleared; they are never exposed before being overwritten in the new frame.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Counters: col counts 0..IMG_WIDTH-1 and increments per accepted pixel. At IMG_WIDTH-1, col wraps to 0 and row increments. When row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both wrap to 0.
- FSM states and transitions:
  - FILL: row<2. Moves to RUN on acceptance of pixel (1,IMG_WIDTH-1).
  - RUN: row>=2. Moves to FILL on acceptance of the last pixel of the frame, which also raises frame_done.
- Line buffers: LB0 holds row r-1, LB1 holds row r-2, each IMG_WIDTH x 8, indexed by col.
  - On an accepted pixel p at (r,c), the new column is {top=LB1[c], mid=LB0[c], bot=p}.
  - Same edge: LB1[c]<=LB0[c], LB0[c]<=p.
  - Read of a location uses its pre-write value.
- Window array: 3 columns x 3 rows of registers. On each accepted pixel, columns shift left and the new column enters on the right. The array holds when pixel_in_valid=0.
- Output rule: for an accepted pixel at (r,c) with r>=2 and c>=2, the next edge registers the window centred at (r-1,c-1):
  - byte0=(r-2,c-2), byte1=(r-2,c-1), byte2=(r-2,c)
  - byte3=(r-1,c-2), byte4=(r-1,c-1), byte5=(r-1,c)
  - byte6=(r,c-2), byte7=(r,c-1), byte8=(r,c)=p
  - window_data_out_valid=1 for exactly that cycle.
  - Latency is 1 clk from pixel acceptance to window output.
- No window is produced for c<2 or r<2. The left-column windows at c=0,1 are stale data spanning the row wrap and must not assert valid.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2); no border padding.
- window_data_out holds its last value when valid is low. The output register updates only on windowed acceptances.
- frame_done is asserted in the same cycle as the final window's valid (1 clk after the last pixel is accepted).
- Back-to-back frames: the first pixel of the next frame may arrive on the cycle immediately after the last pixel of the previous frame, with no bubble required.
- Arithmetic: unsigned counters, width $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT); no saturation needed.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, continuous valid, pixel(r,c)=r*4+c -> exactly 4 windows.
  - First window (1 clk after pixel 10) = 72'h0A0908060504020100.
  - Last window = 72'h0F0E0D0B0A09070605.
  - frame_done high with the 4th valid.
- Same 4x4 frame with pixel_in_valid toggling 1,0,1,0 -> identical 4 windows in order; window_data_out held stable during idle cycles.
- Two back-to-back 4x4 frames, second frame pixel=0x80+r*4+c -> 8 windows total.
  - First window of frame 2 = 72'h8A8988868584828180, with no contamination from frame 1.
  - Two frame_done pulses.
- rstN low for 1 cycle after pixel 7 of a frame, then a full 4x4 frame -> no valid during or after reset until pixel 10 of the new frame.
  - Outputs 0 during reset; windows match the first scenario.
- IMG_WIDTH=8, IMG_HEIGHT=5, random pixels vs software 3x3 reference model -> 18 windows, all bit-exact.
  - No valid for c<2 at any row start.
